coords_ram_arbiter: RTL and testbench
=====================================

# coords_ram_arbiter

Shares the single-port 32 x 32-bit coordinate RAM between the pose-tracker write requesters in the camera pipeline and the Nios II coordinate-read master. Arbitration is round-robin with one RAM command per cycle. Reads are fully pipelined. A lock handshake freezes writers so software can read a consistent set of coordinates for one frame. Sits between the D8M tracking logic, the `nios2_system` coords port and the RAM macro.

## Interface
- `ADDR_W`, 5, RAM address width (32 entries)
- `DATA_W`, 32, RAM word width (packed x/y coordinate)
- `NUM_WR`, 2, number of tracker write requesters (one per player)

- `clk_clk`  in  1  system clock; all logic on its rising edge
- `reset_reset`  in  1  synchronous, active-high reset
- `wr_valid`  in  NUM_WR  write request per writer
- `wr_ready`  out  NUM_WR  write accepted this cycle (valid&ready)
- `wr_addr`  in  NUM_WR*ADDR_W  packed per-writer address, writer i at bits [i*ADDR_W +: ADDR_W]
- `wr_data`  in  NUM_WR*DATA_W  packed per-writer data
- `rd_valid`  in  1  Nios read request
- `rd_ready`  out  1  read accepted this cycle
- `rd_addr`  in  ADDR_W  read address
- `rd_data_valid`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DATA_W  read result, held until next pulse
- `lock_req`  in  1  software requests write freeze
- `lock_ack`  out  1  freeze in effect, all accepted writes committed
- `ram_addr`  out  ADDR_W  RAM address (registered)
- `ram_we`  out  1  RAM write enable (registered)
- `ram_wdata`  out  DATA_W  RAM write data (registered)
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after `ram_addr`

## Operation
- Requester indices: writers 0..NUM_WR-1, reader = NUM_WR.
- Requester eligibility:
  - Writer i is eligible when `wr_valid[i]` is high and `lock_req` is low.
  - The reader is eligible when `rd_valid` is high.
- Grant selection:
  - Each cycle at most one eligible requester is granted: the first eligible index at or after `rr_ptr`, wrapping modulo NUM_WR+1.
  - `wr_ready` and `rd_ready` are combinational from the current inputs and `rr_ptr`.
  - On a grant to index g, `rr_ptr` <= (g+1) mod (NUM_WR+1).
  - With no grant, `rr_ptr` holds.
- Command issue:
  - A granted write registers `ram_we`=1, `ram_addr`, `ram_wdata` for the next cycle.
  - A granted read registers `ram_we`=0 and `ram_addr`=`rd_addr`.
  - With no grant, `ram_we`=0; `ram_addr` and `ram_wdata` hold.
- Read return:
  - A two-stage valid shift register tracks reads in flight.
  - `rd_data` <= `ram_rdata` when the second stage is set.
  - `rd_data_valid` pulses that cycle.
  - There is no limit on reads outstanding; one read is accepted per cycle.
- Ordering:
  - RAM commands execute in grant order, so read-after-write to the same address returns the new data.
  - Writes from different writers to the same address: the later grant wins.
- Lock:
  - `lock_ack` <= `lock_req` (one register).
  - Writers are blocked in the same cycle `lock_req` rises. A write granted the cycle before commits at the end of the following cycle, before `lock_ack` is seen high.
  - Reads are unaffected by lock.
  - When `lock_req` falls, writers become eligible the same cycle; `lock_ack` falls one cycle later.
- Reset, synchronous:
  - `rr_ptr`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - Read pipeline flushed: reads in flight are discarded, no `rd_data_valid` pulse.
  - `rd_data`=0, `rd_data_valid`=0, `lock_ack`=0.
  - `wr_ready` and `rd_ready` are forced 0 while `reset_reset` is high.

## Timing
- Write: accepted cycle N -> `ram_we` high in cycle N+1 -> RAM updated at end of N+1.
- Read: accepted cycle N -> `ram_addr` in N+1 -> `ram_rdata` in N+2 -> `rd_data_valid`/`rd_data` in N+3. Latency 3, throughput 1 per cycle.
- Lock: `lock_req` high in cycle L -> `lock_ack` high in cycle L+1.
- Worst-case wait for any continuously valid requester: NUM_WR cycles.

## Structure
- Shared package `coords_pkg`:
  - `COORD_ADDR_W`=5 and `COORD_DATA_W`=32.
  - Coordinate word typedef: x[15:0] in low half, y[31:16] in high half.
  - These are used by the trackers and this block.
- One sub-module, `rr_arbiter`:
  - Parameterised request count N.
  - Inputs: request vector, `advance` enable. Outputs: one-hot grant.
  - Contains the round-robin pointer register.
- The command register, read pipeline and lock register stay in `coords_ram_arbiter`.
- Behavioural 32x32 RAM model with 1-cycle read latency in the bench only.

## Test plan
- Reset, then single write: writer 0 writes addr 3 = 0x0064_00C8 at cycle 0 -> `ram_we` high cycle 1 with addr 3; a read of addr 3 at cycle 2 returns 0x0064_00C8 with `rd_data_valid` at cycle 5.
- Three-way contention: `wr_valid`=2'b11 and `rd_valid`=1 held from reset -> grants in order w0, w1, rd, w0, …; each requester granted exactly once every 3 cycles.
- Back-to-back reads: addrs 0..31 on 32 consecutive cycles, no writers -> 32 consecutive `rd_data_valid` pulses, first 3 cycles after the first accept, data in address order.
- Lock mid-stream: writer 1 streaming to addr 7 with incrementing data; `lock_req` raised at cycle L:
  - `wr_ready[1]`=0 from L, `lock_ack`=1 at L+1.
  - A read at L+1 returns the last accepted data.
  - RAM addr 7 is unchanged until `lock_req` falls.
- Same-address race: w0 writes 0xAAAA_AAAA and w1 writes 0x5555_5555 to addr 9 in the same cycle, `rr_ptr`=0 -> final RAM value 0x5555_5555.
- Reset with reads in flight: assert `reset_reset` one cycle after a read accept -> no `rd_data_valid` pulse, all outputs at reset values, `rr_ptr` back to 0.

Source files
------------

// File: rtl/coords_pkg.sv
// Coordinate RAM shared definitions.
// Used by the pose trackers and the coordinate RAM arbiter.
package coords_pkg;

  localparam int COORD_ADDR_W = 5;
  localparam int COORD_DATA_W = 32;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } coord_t;

  function automatic coord_t pack_coord(
    input logic [15:0] x,
    input logic [15:0] y
  );
    pack_coord = '{y: y, x: x};
  endfunction

endpackage

// File: rtl/coords_ram_arbiter_rr.sv
// Round-robin arbiter with internal pointer.
// Grants the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] nxt;
  logic [PW-1:0] j;
  logic [SW-1:0] s;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + SW'(k);
      if (s >= SW'(N))
        s = s - SW'(N);
      j = s[PW-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
    nxt = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (advance && found)
      ptr <= nxt;
  end

endmodule

// File: rtl/coords_ram_arbiter.sv
// Shares the coordinate RAM between tracker writers
// and the Nios read master; lock freezes writers.
module coords_ram_arbiter
  import coords_pkg::*;
#(
  parameter int ADDR_W = COORD_ADDR_W,
  parameter int DATA_W = COORD_DATA_W,
  parameter int NUM_WR = 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_WR-1:0]        wr_valid,
  output logic [NUM_WR-1:0]        wr_ready,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_data_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     lock_req,
  output logic                     lock_ack,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int N = NUM_WR + 1;

  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic [1:0]        rd_pipe;
  logic              wr_hit;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // Reader sits at the top index so writers lead after reset.
  always_comb begin
    req = '0;
    if (!reset_reset)
      req = {rd_valid, wr_valid & {NUM_WR{~lock_req}}};
  end

  rr_arbiter #(
    .N(N)
  ) u_rr (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .req     (req),
    .advance (~reset_reset),
    .gnt     (gnt)
  );

  assign wr_ready = gnt[NUM_WR-1:0];
  assign rd_ready = gnt[NUM_WR];

  always_comb begin
    wr_hit = |gnt[NUM_WR-1:0];
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (gnt[i]) begin
        w_addr = wr_addr[i*ADDR_W +: ADDR_W];
        w_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= wr_hit;
      unique case (1'b1)
        wr_hit: begin
          ram_addr  <= w_addr;
          ram_wdata <= w_data;
        end
        rd_ready: ram_addr <= rd_addr;
        default: ;
      endcase
    end
  end

  // Stage 1: command on RAM; stage 2: ram_rdata valid.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_pipe       <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      lock_ack      <= 1'b0;
    end else begin
      rd_pipe       <= {rd_pipe[0], rd_ready};
      rd_data_valid <= rd_pipe[1];
      if (rd_pipe[1])
        rd_data <= ram_rdata;
      lock_ack <= lock_req;
    end
  end

endmodule

// File: tb/tb_coords_ram_arbiter.sv
// Bench for coords_ram_arbiter: RAM model, reference
// model checked every cycle, plus directed literals.
module tb_coords_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_ready;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  rd_addr;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        lock_req;
  logic        lock_ack;
  logic [4:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coords_ram_arbiter #(
    .ADDR_W(5),
    .DATA_W(32),
    .NUM_WR(2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .lock_req      (lock_req),
    .lock_ack      (lock_ack),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  // Single-port RAM, one-cycle read latency
  logic [31:0] mem [32] = '{default: '0};

  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // Reference model: golden memory updated at grant time,
  // read results queued with their due cycle.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] gold [32] = '{default: '0};
  int          m_ptr = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rd = '0;
  logic        m_ack = 1'b0;
  int          ncyc = 0;

  always @(negedge clk) begin
    logic       exp_v;
    logic [2:0] el;
    int         g;
    rd_t        t;
    chk("m_ram_we", ram_we, m_we);
    chk("m_ram_addr", ram_addr, m_addr);
    chk("m_ram_wdata", ram_wdata, m_wdata);
    chk("m_lock_ack", lock_ack, m_ack);
    exp_v = 1'b0;
    if (rq.size() > 0 && rq[0].due == ncyc) begin
      exp_v = 1'b1;
      t = rq.pop_front();
      m_rd = t.data;
    end
    chk("m_rd_valid", rd_data_valid, exp_v);
    chk("m_rd_data", rd_data, m_rd);
    el[0] = wr_valid[0] && !lock_req;
    el[1] = wr_valid[1] && !lock_req;
    el[2] = rd_valid;
    g = -1;
    if (!reset_reset)
      for (int k = 0; k < 3; k++)
        if (g < 0 && el[(m_ptr + k) % 3])
          g = (m_ptr + k) % 3;
    chk("m_wr_ready", wr_ready, {g == 1, g == 0});
    chk("m_rd_ready", rd_ready, g == 2);
    if (reset_reset) begin
      m_ptr   = 0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rd    = '0;
      m_ack   = 1'b0;
      rq.delete();
    end else begin
      m_ack = lock_req;
      m_we  = 1'b0;
      if (g == 0 || g == 1) begin
        m_we    = 1'b1;
        m_addr  = wr_addr[g*5 +: 5];
        m_wdata = wr_data[g*32 +: 32];
        gold[m_addr] = m_wdata;
      end else if (g == 2) begin
        m_addr = rd_addr;
        rq.push_back('{ncyc + 3, gold[rd_addr]});
      end
      if (g >= 0)
        m_ptr = (g + 1) % 3;
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] ra;
    reset_reset = 1'b1;
    wr_valid    = '0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_valid    = 1'b0;
    rd_addr     = '0;
    lock_req    = 1'b0;
    repeat (3) tick();
    smp();
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdv", rd_data_valid, 0);
    chk("rst_ack", lock_ack, 0);

    // single write then read-back
    tick();
    reset_reset   = 1'b0;
    wr_valid      = 2'b01;
    wr_addr[4:0]  = 5'd3;
    wr_data[31:0] = 32'h0064_00C8;
    smp();
    chk("t1_wrdy", wr_ready, 2'b01);
    tick();
    wr_valid = '0;
    smp();
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 3);
    tick();
    rd_valid = 1'b1;
    rd_addr  = 5'd3;
    smp();
    chk("t1_rrdy", rd_ready, 1);
    tick();
    rd_valid = 1'b0;
    smp();
    chk("t1_rdv_c3", rd_data_valid, 0);
    tick();
    smp();
    chk("t1_rdv_c4", rd_data_valid, 0);
    tick();
    smp();
    chk("t1_rdv_c5", rd_data_valid, 1);
    chk("t1_rdata", rd_data, 32'h0064_00C8);

    // three-way contention held through reset
    tick();
    reset_reset = 1'b1;
    wr_valid    = 2'b11;
    rd_valid    = 1'b1;
    wr_addr     = {5'd11, 5'd10};
    wr_data     = {32'hBBBB_0002, 32'hAAAA_0001};
    rd_addr     = 5'd10;
    smp();
    chk("t2_rst_wrdy", wr_ready, 0);
    chk("t2_rst_rrdy", rd_ready, 0);
    tick();
    reset_reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      smp();
      chk("t2_wrdy", wr_ready,
          (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00);
      chk("t2_rrdy", rd_ready, i % 3 == 2);
      tick();
    end
    wr_valid = '0;
    rd_valid = 1'b0;

    // preload, then 32 back-to-back reads
    for (int i = 0; i < 32; i++) begin
      wr_valid      = 2'b01;
      ra            = i[4:0];
      wr_addr[4:0]  = ra;
      wr_data[31:0] = 32'h1000 + i;
      tick();
    end
    wr_valid = '0;
    for (int k = 0; k < 35; k++) begin
      rd_valid = k < 32;
      ra       = k[4:0];
      rd_addr  = ra;
      smp();
      if (k < 32)
        chk("t3_rrdy", rd_ready, 1);
      if (k >= 3) begin
        chk("t3_rdv", rd_data_valid, 1);
        chk("t3_rdata", rd_data, 32'h1000 + k - 3);
      end else begin
        chk("t3_rdv_early", rd_data_valid, 0);
      end
      tick();
    end
    rd_valid = 1'b0;

    // lock during a writer-1 stream to addr 7
    wr_addr[9:5] = 5'd7;
    for (int n = 0; n < 4; n++) begin
      wr_valid       = 2'b10;
      wr_data[63:32] = 32'h100 + n;
      smp();
      chk("t4_wrdy", wr_ready, 2'b10);
      tick();
    end
    lock_req       = 1'b1;
    wr_data[63:32] = 32'h104;
    smp();
    chk("t4_lock_wrdy", wr_ready, 0);
    tick();
    rd_valid = 1'b1;
    rd_addr  = 5'd7;
    smp();
    chk("t4_ack", lock_ack, 1);
    chk("t4_rrdy", rd_ready, 1);
    tick();
    rd_valid = 1'b0;
    smp();
    tick();
    smp();
    tick();
    smp();
    chk("t4_rdv", rd_data_valid, 1);
    chk("t4_rdata", rd_data, 32'h103);
    chk("t4_mem7", mem[7], 32'h103);
    tick();
    smp();
    chk("t4_mem7_held", mem[7], 32'h103);
    tick();
    lock_req = 1'b0;
    smp();
    chk("t4_unlock_wrdy", wr_ready, 2'b10);
    chk("t4_ack_lag", lock_ack, 1);
    tick();
    wr_valid = '0;
    smp();
    chk("t4_ack_fall", lock_ack, 0);

    // same-address race, pointer freshly reset
    tick();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    wr_valid    = 2'b11;
    wr_addr     = {5'd9, 5'd9};
    wr_data     = {32'h5555_5555, 32'hAAAA_AAAA};
    smp();
    chk("t5_first", wr_ready, 2'b01);
    tick();
    smp();
    chk("t5_second", wr_ready, 2'b10);
    tick();
    wr_valid = '0;
    smp();
    tick();
    smp();
    chk("t5_mem9", mem[9], 32'h5555_5555);

    // reset with a read in flight
    tick();
    rd_valid = 1'b1;
    rd_addr  = 5'd9;
    smp();
    chk("t6_rrdy", rd_ready, 1);
    tick();
    rd_valid    = 1'b0;
    reset_reset = 1'b1;
    wr_valid    = 2'b11;
    smp();
    chk("t6_rst_wrdy", wr_ready, 0);
    tick();
    reset_reset = 1'b0;
    wr_valid    = '0;
    smp();
    chk("t6_we", ram_we, 0);
    chk("t6_addr", ram_addr, 0);
    chk("t6_wdata", ram_wdata, 0);
    chk("t6_rdata", rd_data, 0);
    chk("t6_ack", lock_ack, 0);
    chk("t6_rdv", rd_data_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      smp();
      chk("t6_no_rdv", rd_data_valid, 0);
    end
    tick();
    wr_valid = 2'b11;
    rd_valid = 1'b1;
    smp();
    chk("t6_ptr0", wr_ready, 2'b01);
    tick();
    wr_valid = '0;
    rd_valid = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
